// File: rtl/seg_display_arbiter.sv
// Two-requester round-robin arbiter for a 2-digit seven-segment display, with scan and hex decode.
// Optional idle decimal-point blink is enabled by defining IDLE_BLINK_EN.
module seg_display_arbiter #(
    parameter int SCAN_DIV     = 1024,
    parameter int HOLD_CYCLES  = 50000000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic       clk_50M,
    input  logic       rst_button,
    input  logic [1:0] req,
    input  logic [7:0] val0,
    input  logic [7:0] val1,
    output logic [1:0] gnt,
    output logic       busy,
    output logic [7:0] digit_seg,
    output logic [1:0] digit_cath
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

    generate
        if (SCAN_DIV < 2 || HOLD_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_param
            $error("seg_display_arbiter: illegal parameter value");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [HW-1:0]   r_hold;
    logic            r_last;
    logic [SW-1:0]   r_scan;
    logic            r_sel;
    logic [1:0]      r_gnt;
    logic            r_busy;
    logic [7:0]      r_seg;
    logic [1:0]      r_cath;
    logic [7:0]      w_seg;
    logic [1:0]      w_cath;
    logic [7:0]      w_val;
    logic [3:0]      w_nib;

    function automatic logic [7:0] f_decode(input logic [3:0] i_nib);
        logic [7:0] v;
        case (i_nib)
            4'h0: v = 8'hFC;
            4'h1: v = 8'h60;
            4'h2: v = 8'hDA;
            4'h3: v = 8'hF2;
            4'h4: v = 8'h66;
            4'h5: v = 8'hB6;
            4'h6: v = 8'hBE;
            4'h7: v = 8'hE0;
            4'h8: v = 8'hFE;
            4'h9: v = 8'hF6;
            4'hA: v = 8'hEE;
            4'hB: v = 8'h3E;
            4'hC: v = 8'h9C;
            4'hD: v = 8'h7A;
            4'hE: v = 8'h9E;
            default: v = 8'h8E;
        endcase
        return v;
    endfunction

    // A release always wins over a slice expiry, so there is never a double switch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req[0] && req[1]) w_next = r_last ? OWN0 : OWN1;
                else if (req[0])      w_next = OWN0;
                else if (req[1])      w_next = OWN1;
            end
            OWN0: begin
                if (!req[0])                         w_next = req[1] ? OWN1 : IDLE;
                else if (req[1] && r_hold == HOLD_MAX) w_next = OWN1;
            end
            OWN1: begin
                if (!req[1])                         w_next = req[0] ? OWN0 : IDLE;
                else if (req[0] && r_hold == HOLD_MAX) w_next = OWN0;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or posedge rst_button) begin
        if (rst_button) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_gnt   <= {w_next == OWN1, w_next == OWN0};
            r_busy  <= (w_next != IDLE);
            if (w_next != r_state)
                r_hold <= '0;
            else if (r_state != IDLE && r_hold != HOLD_MAX)
                r_hold <= r_hold + 1'b1;
            if (w_next == OWN0 && r_state != OWN0) r_last <= 1'b0;
            if (w_next == OWN1 && r_state != OWN1) r_last <= 1'b1;
        end
    end

    always_ff @(posedge clk_50M or posedge rst_button) begin
        if (rst_button) begin
            r_scan <= '0;
            r_sel  <= 1'b0;
        end else if (r_scan == SCAN_MAX) begin
            r_scan <= '0;
            r_sel  <= ~r_sel;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

`ifdef IDLE_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);
    logic [BW-1:0] r_blink;
    logic          r_phase;

    always_ff @(posedge clk_50M or posedge rst_button) begin
        if (rst_button) begin
            r_blink <= '0;
            r_phase <= 1'b0;
        end else if (r_blink == BLINK_MAX) begin
            r_blink <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_blink <= r_blink + 1'b1;
        end
    end
`endif

    always_comb begin
        w_seg  = 8'h00;
        w_cath = 2'b00;
        w_val  = (r_state == OWN1) ? val1 : val0;
        w_nib  = r_sel ? w_val[7:4] : w_val[3:0];
        if (r_state == OWN0 || r_state == OWN1) begin
            w_cath = r_sel ? 2'b10 : 2'b01;
            w_seg  = f_decode(w_nib);
        end
`ifdef IDLE_BLINK_EN
        else if (r_phase) begin
            w_cath = r_sel ? 2'b10 : 2'b01;
            w_seg  = 8'h01;
        end
`endif
    end

    always_ff @(posedge clk_50M or posedge rst_button) begin
        if (rst_button) begin
            r_seg  <= 8'h00;
            r_cath <= 2'b00;
        end else begin
            r_seg  <= w_seg;
            r_cath <= w_cath;
        end
    end

    assign gnt        = r_gnt;
    assign busy       = r_busy;
    assign digit_seg  = r_seg;
    assign digit_cath = r_cath;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with SCAN_DIV=4, HOLD_CYCLES=16.
// Covers reset, scan/decode, round-robin, preemption, saturation and release.
module tb_seg_display_arbiter;

    logic       clk_50M = 1'b0;
    logic       rst_button = 1'b1;
    logic [1:0] req = 2'b00;
    logic [7:0] val0 = 8'h00;
    logic [7:0] val1 = 8'h00;
    logic [1:0] gnt;
    logic       busy;
    logic [7:0] digit_seg;
    logic [1:0] digit_cath;

    int n_checks = 0;
    int n_errors = 0;

    seg_display_arbiter #(
        .SCAN_DIV    (4),
        .HOLD_CYCLES (16),
        .BLINK_CYCLES(8)
    ) dut (
        .clk_50M   (clk_50M),
        .rst_button(rst_button),
        .req       (req),
        .val0      (val0),
        .val1      (val1),
        .gnt       (gnt),
        .busy      (busy),
        .digit_seg (digit_seg),
        .digit_cath(digit_cath)
    );

    always #5 clk_50M = ~clk_50M;

    typedef struct {
        logic [1:0] req;
        logic [7:0] v0;
        logic [1:0] gnt;
        logic       busy;
        logic [7:0] seg;
        logic [1:0] cath;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    // Leaves time at #1 after a posedge with all counters at zero.
    task automatic do_reset();
        rst_button = 1'b1;
        req = 2'b00;
        repeat (2) @(posedge clk_50M);
        #1;
        rst_button = 1'b0;
    endtask

    function automatic logic [7:0] dec(input logic [3:0] n);
        logic [7:0] t[16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                              8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
        return t[n];
    endfunction

    initial begin
        logic [1:0] eg;
        logic       hi;
        logic [7:0] v;

        tbl[0] = '{2'b01, 8'h3A, 2'b01, 1'b1, 8'h00, 2'b00};
        tbl[1] = '{2'b01, 8'h3A, 2'b01, 1'b1, 8'hEE, 2'b01};
        tbl[2] = '{2'b01, 8'h3A, 2'b01, 1'b1, 8'hEE, 2'b01};
        tbl[3] = '{2'b01, 8'h3A, 2'b01, 1'b1, 8'hEE, 2'b01};
        tbl[4] = '{2'b01, 8'h3A, 2'b01, 1'b1, 8'hF2, 2'b10};
        tbl[5] = '{2'b01, 8'h3A, 2'b01, 1'b1, 8'hF2, 2'b10};
        tbl[6] = '{2'b01, 8'h3A, 2'b01, 1'b1, 8'hF2, 2'b10};
        tbl[7] = '{2'b01, 8'h3A, 2'b01, 1'b1, 8'hF2, 2'b10};
        tbl[8] = '{2'b01, 8'h3A, 2'b01, 1'b1, 8'hEE, 2'b01};

        #2;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_seg", digit_seg, 8'h00);
        chk("rst_cath", digit_cath, 2'b00);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            req  = tbl[i].req;
            val0 = tbl[i].v0;
            step();
            chk($sformatf("scan%0d_gnt", i), gnt, tbl[i].gnt);
            chk($sformatf("scan%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("scan%0d_seg", i), digit_seg, tbl[i].seg);
            chk($sformatf("scan%0d_cath", i), digit_cath, tbl[i].cath);
        end

        do_reset();
        req = 2'b11;
        step();
        chk("rr_first", gnt, 2'b01);
        req = 2'b10;
        step();
        chk("rr_handoff", gnt, 2'b10);
        chk("rr_handoff_busy", busy, 1'b1);
        req = 2'b01;
        step();
        chk("rr_back", gnt, 2'b01);
        req = 2'b00;
        step();
        chk("rel_gnt", gnt, 2'b00);
        chk("rel_busy", busy, 1'b0);
        step();
        chk("rel_cath", digit_cath, 2'b00);
        chk("rel_seg", digit_seg, 8'h00);
        req = 2'b11;
        step();
        chk("rr_idle_contest", gnt, 2'b10);

        do_reset();
        req = 2'b01;
        for (int k = 1; k <= 36; k++) begin
            step();
            eg = (k <= 16) ? 2'b01 : (k <= 32) ? 2'b10 : 2'b01;
            chk($sformatf("preempt_k%0d", k), gnt, eg);
            if (k == 3) req = 2'b11;
        end

        do_reset();
        req  = 2'b10;
        val1 = 8'h5C;
        for (int n = 1; n <= 100; n++) begin
            step();
            chk($sformatf("sat_gnt_n%0d", n), gnt, 2'b10);
            if (n >= 2) begin
                hi = (((n - 1) / 4) % 2) == 1;
                v  = (n >= 51) ? 8'h12 : 8'h5C;
                chk($sformatf("sat_cath_n%0d", n), digit_cath, hi ? 2'b10 : 2'b01);
                chk($sformatf("sat_seg_n%0d", n), digit_seg, dec(hi ? v[7:4] : v[3:0]));
            end
            if (n == 50) val1 = 8'h12;
        end

        #2;
        rst_button = 1'b1;
        #1;
        chk("async_gnt", gnt, 2'b00);
        chk("async_busy", busy, 1'b0);
        chk("async_seg", digit_seg, 8'h00);
        chk("async_cath", digit_cath, 2'b00);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
